ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Registered, parametrised successor to the ID-stage control decoder.
- Decodes mode/opcode/S into EXE controls and drives them from an ID/EX-side output register with a valid/ready handshake, downstream hold and flush.
- Adds block-transfer support (LDM/STM): one instruction with a register list is expanded into one memory micro-op per set bit, stalling the front end until done.

Parameters:
- LIST_W, 16, register-list width; one bit per architectural register.
- EXE_W, 4, exe_command width.
- IDX_W, $clog2(LIST_W), derived localparam; register index / micro-op count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction fields present
- in_ready  out  1  sequencer accepts instruction this cycle
- mode_in  in  2  instruction mode field
- opcode_in  in  4  opcode field
- s_in  in  1  S bit (load/store select in mode 01)
- reg_list_in  in  LIST_W  block-transfer register list
- hold_in  in  1  downstream stall; freezes output register and sequencer
- flush_in  in  1  kill in-flight output and any block sequence
- out_valid  out  1  output register holds a live op
- wb_enable, mem_read, mem_write, s_out, branch_out  out  1 each  registered controls
- exe_command  out  EXE_W  registered ALU command
- dest_idx_out  out  IDX_W  register index for the block micro-op (0 for non-block ops)
- offset_out  out  IDX_W+2  byte offset, micro-op count × 4 (0 for non-block ops)
- busy  out  1  block sequence in progress

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous and active-high.
  - On reset, all outputs are 0 except in_ready = 1; state is IDLE and internal list/count registers are 0.
- in_ready = (state == IDLE) && !hold_in && !rst.
- Accept occurs when in_valid && in_ready. Decoded controls appear on the outputs on the next clock edge, giving one cycle of latency.
- Decode (mode 00, data-processing):
  - s_out = s_in.
  - MOV 1101→1, MVN 1111→9, ADD 0100→2, ADC 0101→3, SUB 0010→4, SBC 0110→5, AND 0000→6, ORR 1100→7, EOR 0001→8: each with wb = 1.
  - CMP 1010→4 and TST 1000→6: wb = 0.
  - Any other opcode: exe = 0, wb = 0.
- Decode (mode 01, memory):
  - Opcode 0100, single LDR/STR: exe = 2.
    - s = 1 → mem_read = 1, wb = 1.
    - s = 0 → mem_write = 1, wb = 0.
  - Opcode 1000, block LDM/STM: enter BLOCK (see below).
  - Other opcodes: all enables 0.
- Decode (other modes):
  - Mode 10 (branch): branch_out = 1; wb, mem and exe are 0.
  - Mode 11: all enables 0.
  - s_out = 0 in every mode except 00.
- No-accept cycles: when there is no accept and no hold, out_valid = 0 (bubble).
- State machine: IDLE, BLOCK.
  - Block accept with a nonzero list:
    - Latch the list, set count = 0 and go to BLOCK.
    - Emit the first micro-op on the accept edge.
    - Each micro-op: exe = 2, dest_idx_out = index of the lowest set bit, offset_out = count × 4. LDM (s = 1) sets mem_read = 1, wb = 1; STM (s = 0) sets mem_write = 1, wb = 0.
    - After each emit, clear that bit and increment count.
  - In BLOCK, each non-held cycle emits the next micro-op.
  - After the last set bit is emitted, return to IDLE. An N-bit list yields exactly N consecutive valid micro-ops.
  - A single-bit list never enters BLOCK; it behaves like a single op.
  - Block accept with an empty list: emits one op with out_valid = 1 and all enables and exe = 0.
  - busy = (state == BLOCK).
- hold_in = 1: the output register, state, list and count are all frozen, and in_ready = 0.
- flush_in = 1: on the next edge out_valid = 0, state returns to IDLE and the list is cleared. Any accept in the same cycle is discarded.
- Priority: rst > flush_in > hold_in > normal operation.
- Boundaries:
  - List bit LIST_W-1 set: index LIST_W-1, offset up to (LIST_W-1) × 4. This must not overflow IDX_W+2 bits.
  - Full list of LIST_W bits: exactly LIST_W micro-ops.

Decomposition:
- Shared package ctrl_pkg holds:
  - mode constants: MODE_DP, MODE_MEM, MODE_BR;
  - opcode constants, including OP_BLOCK = 4'b1000 in mode 01;
  - EXE_* command codes;
  - the state enum {IDLE, BLOCK}.
- One sub-module, lsb_index_enc: LIST_W-wide lowest-set-bit priority encoder with outputs idx and any.

Test Plan:
- ADD (mode 00, op 0100, s = 1), no hold → next cycle out_valid = 1, exe = 2, wb = 1, s_out = 1; the following cycle out_valid = 0.
- CMP (op 1010) then STR (mode 01, op 0100, s = 0) → exe = 4, wb = 0; then exe = 2, mem_write = 1, wb = 0, s_out = 0.
- LDM with list 16'h8025 → four micro-ops with dest 0/2/5/15, offset 0/4/8/12, mem_read = wb = 1. in_ready = 0 and busy = 1 throughout, returning to IDLE after the 4th.
- STM with list 16'h0006, hold_in asserted for 2 cycles after the first micro-op → outputs frozen (dest 1, offset 0) for 2 cycles, then dest 2, offset 4, mem_write = 1.
- LDM with list 16'hFFFF, flush_in on the 3rd micro-op → out_valid = 0 next cycle, busy = 0, in_ready = 1. A new ADD then decodes normally.
- Branch (mode 10) → branch_out = 1, wb = 0. Empty-list LDM → one op with all enables 0. rst mid-BLOCK → all outputs 0, in_ready = 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and types for the ID/EX control sequencer.
//   - MODE_* : instruction mode field encodings
//   - OP_*   : opcode field encodings (data-processing and memory)
//   - EXE_*  : ALU command codes driven on exe_command
//   - state_e: sequencer FSM state
//   - decode_dp(): data-processing opcode -> {wb, exe}
package ctrl_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Data-processing opcodes (mode 00)
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Memory opcodes (mode 01)
    localparam logic [3:0] OP_LDST  = 4'b0100;
    localparam logic [3:0] OP_BLOCK = 4'b1000;

    // ALU command codes
    localparam logic [3:0] EXE_NOP = 4'd0;
    localparam logic [3:0] EXE_MOV = 4'd1;
    localparam logic [3:0] EXE_ADD = 4'd2;
    localparam logic [3:0] EXE_ADC = 4'd3;
    localparam logic [3:0] EXE_SUB = 4'd4;
    localparam logic [3:0] EXE_SBC = 4'd5;
    localparam logic [3:0] EXE_AND = 4'd6;
    localparam logic [3:0] EXE_ORR = 4'd7;
    localparam logic [3:0] EXE_EOR = 4'd8;
    localparam logic [3:0] EXE_MVN = 4'd9;
    // Address generation for loads/stores reuses the adder.
    localparam logic [3:0] EXE_LDST = EXE_ADD;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } state_e;

    typedef struct packed {
        logic       wb;
        logic [3:0] exe;
    } dp_dec_t;

    // CMP/TST only set flags, so they run the ALU without writeback.
    function automatic dp_dec_t decode_dp(input logic [3:0] op);
        dp_dec_t d;
        d = '{wb: 1'b0, exe: EXE_NOP};
        case (op)
            OP_MOV: d = '{wb: 1'b1, exe: EXE_MOV};
            OP_MVN: d = '{wb: 1'b1, exe: EXE_MVN};
            OP_ADD: d = '{wb: 1'b1, exe: EXE_ADD};
            OP_ADC: d = '{wb: 1'b1, exe: EXE_ADC};
            OP_SUB: d = '{wb: 1'b1, exe: EXE_SUB};
            OP_SBC: d = '{wb: 1'b1, exe: EXE_SBC};
            OP_AND: d = '{wb: 1'b1, exe: EXE_AND};
            OP_ORR: d = '{wb: 1'b1, exe: EXE_ORR};
            OP_EOR: d = '{wb: 1'b1, exe: EXE_EOR};
            OP_CMP: d = '{wb: 1'b0, exe: EXE_SUB};
            OP_TST: d = '{wb: 1'b0, exe: EXE_AND};
            default: d = '{wb: 1'b0, exe: EXE_NOP};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsb_index_enc.sv
// lsb_index_enc: lowest-set-bit priority encoder.
//   vec_in : LIST_W-bit input vector
//   idx    : index of the lowest set bit (0 when vec_in is zero)
//   any    : 1 when any bit of vec_in is set
module lsb_index_enc #(
    parameter int  LIST_W = 16,
    localparam int IDX_W  = $clog2(LIST_W)
) (
    input  logic [LIST_W-1:0] vec_in,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    // Scan from the top down so the last hit, the lowest set bit, wins.
    always_comb begin
        idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (vec_in[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec_in;

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: registered ID-stage control decoder with LDM/STM expansion.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : instruction handshake; accept = in_valid && in_ready.
//                       in_ready is high only in IDLE, not held, not in reset.
//   mode_in, opcode_in, s_in, reg_list_in : instruction fields
//   hold_in           : freeze output register and sequencer state
//   flush_in          : kill the output and any block sequence (beats hold)
//   out_valid + wb_enable, mem_read, mem_write, s_out, branch_out,
//   exe_command, dest_idx_out, offset_out : registered EXE controls,
//                       valid one cycle after accept
//   busy              : a block transfer is being expanded
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int  LIST_W = 16,
    parameter int  EXE_W  = 4,
    localparam int IDX_W  = $clog2(LIST_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode_in,
    input  logic [3:0]        opcode_in,
    input  logic              s_in,
    input  logic [LIST_W-1:0] reg_list_in,
    input  logic              hold_in,
    input  logic              flush_in,
    output logic              out_valid,
    output logic              wb_enable,
    output logic              mem_read,
    output logic              mem_write,
    output logic              s_out,
    output logic              branch_out,
    output logic [EXE_W-1:0]  exe_command,
    output logic [IDX_W-1:0]  dest_idx_out,
    output logic [IDX_W+1:0]  offset_out,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [LIST_W-1:0]   list_q, list_d;
    logic [IDX_W-1:0]    count_q, count_d;
    logic                blk_load_q, blk_load_d;

    logic                valid_q, valid_d;
    logic                wb_q, wb_d;
    logic                mrd_q, mrd_d;
    logic                mwr_q, mwr_d;
    logic                s_q, s_d;
    logic                br_q, br_d;
    logic [EXE_W-1:0]    exe_q, exe_d;
    logic [IDX_W-1:0]    dest_q, dest_d;
    logic [IDX_W+1:0]    off_q, off_d;

    logic [LIST_W-1:0]   enc_vec;
    logic [IDX_W-1:0]    enc_idx;
    logic                enc_any;
    logic [LIST_W-1:0]   rest_list;
    logic                accept;
    dp_dec_t             dp_dec;

    // One encoder serves both the incoming list (IDLE) and the remaining list (BLOCK).
    assign enc_vec = (state_q == BLOCK) ? list_q : reg_list_in;

    lsb_index_enc #(.LIST_W(LIST_W)) u_lsb_enc (
        .vec_in (enc_vec),
        .idx    (enc_idx),
        .any    (enc_any)
    );

    // Clearing the lowest set bit: x & (x - 1).
    assign rest_list = enc_vec & (enc_vec - LIST_W'(1));

    assign in_ready = (state_q == IDLE) && !hold_in && !rst;
    assign accept   = in_valid && in_ready;
    assign dp_dec   = decode_dp(opcode_in);

    always_comb begin
        state_d    = state_q;
        list_d     = list_q;
        count_d    = count_q;
        blk_load_d = blk_load_q;
        valid_d    = valid_q;
        wb_d       = wb_q;
        mrd_d      = mrd_q;
        mwr_d      = mwr_q;
        s_d        = s_q;
        br_d       = br_q;
        exe_d      = exe_q;
        dest_d     = dest_q;
        off_d      = off_q;

        if (flush_in) begin
            state_d = IDLE;
            list_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
            wb_d    = 1'b0;
            mrd_d   = 1'b0;
            mwr_d   = 1'b0;
            s_d     = 1'b0;
            br_d    = 1'b0;
            exe_d   = '0;
            dest_d  = '0;
            off_d   = '0;
        end else if (hold_in) begin
            // everything keeps its current value
        end else begin
            // Bubble unless something below emits.
            valid_d = 1'b0;
            wb_d    = 1'b0;
            mrd_d   = 1'b0;
            mwr_d   = 1'b0;
            s_d     = 1'b0;
            br_d    = 1'b0;
            exe_d   = '0;
            dest_d  = '0;
            off_d   = '0;

            if (state_q == BLOCK) begin
                valid_d = 1'b1;
                exe_d   = EXE_W'(EXE_LDST);
                wb_d    = blk_load_q;
                mrd_d   = blk_load_q;
                mwr_d   = !blk_load_q;
                dest_d  = enc_idx;
                off_d   = {count_q, 2'b00};
                list_d  = rest_list;
                count_d = count_q + IDX_W'(1);
                if (rest_list == '0) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end else if (accept) begin
                valid_d = 1'b1;
                case (mode_in)
                    MODE_DP: begin
                        s_d   = s_in;
                        wb_d  = dp_dec.wb;
                        exe_d = EXE_W'(dp_dec.exe);
                    end
                    MODE_MEM: begin
                        if (opcode_in == OP_LDST) begin
                            exe_d = EXE_W'(EXE_LDST);
                            wb_d  = s_in;
                            mrd_d = s_in;
                            mwr_d = !s_in;
                        end else if (opcode_in == OP_BLOCK && enc_any) begin
                            // First micro-op goes out on the accept edge; only
                            // lists with more bits left enter BLOCK.
                            exe_d = EXE_W'(EXE_LDST);
                            wb_d  = s_in;
                            mrd_d = s_in;
                            mwr_d = !s_in;
                            dest_d = enc_idx;
                            off_d  = '0;
                            if (rest_list != '0) begin
                                state_d    = BLOCK;
                                list_d     = rest_list;
                                count_d    = IDX_W'(1);
                                blk_load_d = s_in;
                            end
                        end
                        // empty block list and other opcodes: valid no-op
                    end
                    MODE_BR: begin
                        br_d = 1'b1;
                    end
                    default: begin
                        // mode 11: valid no-op
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            list_q     <= '0;
            count_q    <= '0;
            blk_load_q <= 1'b0;
            valid_q    <= 1'b0;
            wb_q       <= 1'b0;
            mrd_q      <= 1'b0;
            mwr_q      <= 1'b0;
            s_q        <= 1'b0;
            br_q       <= 1'b0;
            exe_q      <= '0;
            dest_q     <= '0;
            off_q      <= '0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            count_q    <= count_d;
            blk_load_q <= blk_load_d;
            valid_q    <= valid_d;
            wb_q       <= wb_d;
            mrd_q      <= mrd_d;
            mwr_q      <= mwr_d;
            s_q        <= s_d;
            br_q       <= br_d;
            exe_q      <= exe_d;
            dest_q     <= dest_d;
            off_q      <= off_d;
        end
    end

    assign out_valid    = valid_q;
    assign wb_enable    = wb_q;
    assign mem_read     = mrd_q;
    assign mem_write    = mwr_q;
    assign s_out        = s_q;
    assign branch_out   = br_q;
    assign exe_command  = exe_q;
    assign dest_idx_out = dest_q;
    assign offset_out   = off_q;
    assign busy         = (state_q == BLOCK);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed table-driven bench for ctrl_sequencer.
module tb_ctrl_sequencer;

  localparam int LIST_W = 16;
  localparam int EXE_W  = 4;
  localparam int IDX_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode_in;
  logic [3:0]        opcode_in;
  logic              s_in;
  logic [LIST_W-1:0] reg_list_in;
  logic              hold_in;
  logic              flush_in;
  logic              out_valid, wb_enable, mem_read, mem_write, s_out, branch_out;
  logic [EXE_W-1:0]  exe_command;
  logic [IDX_W-1:0]  dest_idx_out;
  logic [IDX_W+1:0]  offset_out;
  logic              busy;

  int checks = 0;
  int failures = 0;

  ctrl_sequencer #(.LIST_W(LIST_W), .EXE_W(EXE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode_in      (mode_in),
    .opcode_in    (opcode_in),
    .s_in         (s_in),
    .reg_list_in  (reg_list_in),
    .hold_in      (hold_in),
    .flush_in     (flush_in),
    .out_valid    (out_valid),
    .wb_enable    (wb_enable),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .s_out        (s_out),
    .branch_out   (branch_out),
    .exe_command  (exe_command),
    .dest_idx_out (dest_idx_out),
    .offset_out   (offset_out),
    .busy         (busy)
  );

  // clock
  always #5 clk = ~clk;

  // Output bundle: {valid, wb, mrd, mwr, s, br, exe[3:0], dest[3:0], off[5:0]}
  function automatic logic [19:0] mk(input logic v, input logic wb, input logic mr,
                                     input logic mw, input logic s, input logic br,
                                     input logic [3:0] exe, input logic [3:0] dest,
                                     input logic [5:0] off);
    return {v, wb, mr, mw, s, br, exe, dest, off};
  endfunction

  function automatic logic [19:0] dut_bundle();
    return {out_valid, wb_enable, mem_read, mem_write, s_out, branch_out,
            exe_command, dest_idx_out, offset_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [19:0] exp);
    check(name, {12'h0, dut_bundle()}, {12'h0, exp});
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for exactly one cycle
  task automatic issue(input logic [1:0] m, input logic [3:0] op, input logic s,
                       input logic [15:0] lst);
    in_valid    = 1'b1;
    mode_in     = m;
    opcode_in   = op;
    s_in        = s;
    reg_list_in = lst;
    step();
    in_valid    = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  op;
    logic        s;
    logic [15:0] lst;
    logic [19:0] exp;
  } vec_t;

  vec_t vq[$];
  logic [15:0] ldm_exp_dest[4];

  initial begin
    // driver defaults and reset
    rst = 1'b1;
    in_valid = 1'b0;
    mode_in = 2'b00;
    opcode_in = 4'b0000;
    s_in = 1'b0;
    reg_list_in = '0;
    hold_in = 1'b0;
    flush_in = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check_out("reset_outputs", mk(0,0,0,0,0,0,4'd0,4'd0,6'd0));
    check("reset_in_ready", {31'h0, in_ready}, 32'd1);
    check("reset_busy", {31'h0, busy}, 32'd0);

    // mode, op, s, list, expected bundle
    vq.push_back('{2'b00, 4'b0100, 1'b1, 16'h0000, mk(1,1,0,0,1,0,4'd2,4'd0,6'd0)}); // ADD
    vq.push_back('{2'b00, 4'b1010, 1'b0, 16'h0000, mk(1,0,0,0,0,0,4'd4,4'd0,6'd0)}); // CMP
    vq.push_back('{2'b01, 4'b0100, 1'b0, 16'h0000, mk(1,0,0,1,0,0,4'd2,4'd0,6'd0)}); // STR
    vq.push_back('{2'b01, 4'b0100, 1'b1, 16'h0000, mk(1,1,1,0,0,0,4'd2,4'd0,6'd0)}); // LDR
    vq.push_back('{2'b00, 4'b1101, 1'b0, 16'h0000, mk(1,1,0,0,0,0,4'd1,4'd0,6'd0)}); // MOV
    vq.push_back('{2'b00, 4'b1111, 1'b1, 16'h0000, mk(1,1,0,0,1,0,4'd9,4'd0,6'd0)}); // MVN
    vq.push_back('{2'b00, 4'b0101, 1'b0, 16'h0000, mk(1,1,0,0,0,0,4'd3,4'd0,6'd0)}); // ADC
    vq.push_back('{2'b00, 4'b0010, 1'b0, 16'h0000, mk(1,1,0,0,0,0,4'd4,4'd0,6'd0)}); // SUB
    vq.push_back('{2'b00, 4'b0110, 1'b0, 16'h0000, mk(1,1,0,0,0,0,4'd5,4'd0,6'd0)}); // SBC
    vq.push_back('{2'b00, 4'b0000, 1'b0, 16'h0000, mk(1,1,0,0,0,0,4'd6,4'd0,6'd0)}); // AND
    vq.push_back('{2'b00, 4'b1100, 1'b0, 16'h0000, mk(1,1,0,0,0,0,4'd7,4'd0,6'd0)}); // ORR
    vq.push_back('{2'b00, 4'b0001, 1'b0, 16'h0000, mk(1,1,0,0,0,0,4'd8,4'd0,6'd0)}); // EOR
    vq.push_back('{2'b00, 4'b1000, 1'b1, 16'h0000, mk(1,0,0,0,1,0,4'd6,4'd0,6'd0)}); // TST
    vq.push_back('{2'b00, 4'b0011, 1'b0, 16'h0000, mk(1,0,0,0,0,0,4'd0,4'd0,6'd0)}); // undefined DP
    vq.push_back('{2'b10, 4'b0000, 1'b1, 16'h0000, mk(1,0,0,0,0,1,4'd0,4'd0,6'd0)}); // branch
    vq.push_back('{2'b11, 4'b0100, 1'b1, 16'h0000, mk(1,0,0,0,0,0,4'd0,4'd0,6'd0)}); // mode 11
    vq.push_back('{2'b01, 4'b0001, 1'b1, 16'h0000, mk(1,0,0,0,0,0,4'd0,4'd0,6'd0)}); // mem other op
    vq.push_back('{2'b01, 4'b1000, 1'b1, 16'h0000, mk(1,0,0,0,0,0,4'd0,4'd0,6'd0)}); // empty LDM
    vq.push_back('{2'b01, 4'b1000, 1'b1, 16'h8000, mk(1,1,1,0,0,0,4'd2,4'd15,6'd0)}); // 1-bit LDM
    vq.push_back('{2'b01, 4'b1000, 1'b0, 16'h0010, mk(1,0,0,1,0,0,4'd2,4'd4,6'd0)}); // 1-bit STM

    for (int i = 0; i < vq.size(); i++) begin
      issue(vq[i].mode, vq[i].op, vq[i].s, vq[i].lst);
      check_out($sformatf("vec%0d_out", i), vq[i].exp);
      check($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'd0);
      check($sformatf("vec%0d_ready", i), {31'h0, in_ready}, 32'd1);
      step();
      check($sformatf("vec%0d_bubble", i), {31'h0, out_valid}, 32'd0);
    end

    // LDM 8025: four micro-ops, dest 0/2/5/15
    ldm_exp_dest[0] = 16'd0;
    ldm_exp_dest[1] = 16'd2;
    ldm_exp_dest[2] = 16'd5;
    ldm_exp_dest[3] = 16'd15;
    issue(2'b01, 4'b1000, 1'b1, 16'h8025);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      check_out($sformatf("ldm8025_uop%0d", k),
                mk(1,1,1,0,0,0,4'd2,ldm_exp_dest[k][3:0],6'(k*4)));
      check($sformatf("ldm8025_busy%0d", k), {31'h0, busy}, (k < 3) ? 32'd1 : 32'd0);
      check($sformatf("ldm8025_ready%0d", k), {31'h0, in_ready}, (k < 3) ? 32'd0 : 32'd1);
    end
    step();
    check("ldm8025_after", {31'h0, out_valid}, 32'd0);

    // STM 0006 with a two-cycle hold after the first micro-op
    issue(2'b01, 4'b1000, 1'b0, 16'h0006);
    check_out("stm_uop0", mk(1,0,0,1,0,0,4'd2,4'd1,6'd0));
    hold_in = 1'b1;
    #1;
    check("stm_hold_ready", {31'h0, in_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check_out($sformatf("stm_hold%0d", k), mk(1,0,0,1,0,0,4'd2,4'd1,6'd0));
      check($sformatf("stm_hold_busy%0d", k), {31'h0, busy}, 32'd1);
    end
    hold_in = 1'b0;
    step();
    check_out("stm_uop1", mk(1,0,0,1,0,0,4'd2,4'd2,6'd4));
    check("stm_done_busy", {31'h0, busy}, 32'd0);
    step();

    // Full list: 16 micro-ops, last one at dest 15 / offset 60
    issue(2'b01, 4'b1000, 1'b1, 16'hFFFF);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      check_out($sformatf("full_uop%0d", k), mk(1,1,1,0,0,0,4'd2,4'(k),6'(k*4)));
    end
    check("full_done_busy", {31'h0, busy}, 32'd0);
    step();
    check("full_after", {31'h0, out_valid}, 32'd0);

    // LDM FFFF flushed while the 3rd micro-op is on the outputs
    issue(2'b01, 4'b1000, 1'b1, 16'hFFFF);
    step();
    step();
    check_out("flush_uop2", mk(1,1,1,0,0,0,4'd2,4'd2,6'd8));
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    #1;
    check("flush_valid", {31'h0, out_valid}, 32'd0);
    check("flush_busy", {31'h0, busy}, 32'd0);
    check("flush_ready", {31'h0, in_ready}, 32'd1);
    step();
    check("flush_quiet", {31'h0, out_valid}, 32'd0);
    issue(2'b00, 4'b0100, 1'b1, 16'h0000);
    check_out("post_flush_add", mk(1,1,0,0,1,0,4'd2,4'd0,6'd0));

    // accept in the same cycle as flush is discarded
    flush_in = 1'b1;
    issue(2'b00, 4'b1101, 1'b0, 16'h0000);
    flush_in = 1'b0;
    check_out("flush_discard", mk(0,0,0,0,0,0,4'd0,4'd0,6'd0));
    check("flush_discard_busy", {31'h0, busy}, 32'd0);

    // reset in the middle of a block
    issue(2'b01, 4'b1000, 1'b0, 16'h00F0);
    step();
    check_out("rst_pre_uop1", mk(1,0,0,1,0,0,4'd2,4'd5,6'd4));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_out("rst_mid_outputs", mk(0,0,0,0,0,0,4'd0,4'd0,6'd0));
    check("rst_mid_busy", {31'h0, busy}, 32'd0);
    check("rst_mid_ready", {31'h0, in_ready}, 32'd1);
    issue(2'b01, 4'b0100, 1'b1, 16'h0000);
    check_out("post_rst_ldr", mk(1,1,1,0,0,0,4'd2,4'd0,6'd0));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
